// File: rtl/dram_read_arbiter.sv
// Round-robin arbiter sharing one DRAM read port among NUM_REQ requesters.
// One burst is outstanding at a time. Beats are forwarded one cycle late, and error flags are sticky.
module dram_read_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned DRAM_DATA_WIDTH = 512,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  localparam int unsigned GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_pixel,
  input  logic                          dram_arbiter_reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]          req_len,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DRAM_DATA_WIDTH-1:0]    rsp_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [AXI_ADDR_WIDTH-1:0]     dram_read_addr,
  output logic [7:0]                    dram_read_len,
  output logic                          dram_read_en,
  input  logic [DRAM_DATA_WIDTH-1:0]    dram_read_data,
  input  logic                          dram_read_data_valid,
  input  logic                          dram_read_busy,
  output logic [GID_W-1:0]              arb_grant_id,
  output logic                          arb_busy,
  output logic                          arb_timeout,
  output logic                          arb_stray
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GID_W:0] NumReq = (GID_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitData} state_e;

  state_e           state_q;
  logic [GID_W-1:0] rr_ptr_q;
  logic [8:0]       beat_cnt_q;
  logic [TW-1:0]    tmo_cnt_q;

  logic [GID_W-1:0] pick;
  logic             found;
  logic [GID_W:0]   idx;
  logic [GID_W:0]   rr_inc;
  logic [GID_W-1:0] rr_next;

  // First requesting index at or after rr_ptr, searched cyclically.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (GID_W + 1)'(k);
      if (idx >= NumReq) idx = idx - NumReq;
      if (!found && req_valid[idx[GID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[GID_W-1:0];
      end
    end
  end

  always_comb begin
    rr_inc  = {1'b0, arb_grant_id} + 1'b1;
    rr_next = (rr_inc >= NumReq) ? '0 : rr_inc[GID_W-1:0];
  end

  assign arb_busy = (state_q != StIdle);

  always_ff @(posedge clk_pixel) begin
    if (dram_arbiter_reset) begin
      state_q        <= StIdle;
      rr_ptr_q       <= '0;
      beat_cnt_q     <= '0;
      tmo_cnt_q      <= '0;
      arb_grant_id   <= '0;
      req_ready      <= '0;
      rsp_valid      <= '0;
      rsp_data       <= '0;
      dram_read_en   <= 1'b0;
      dram_read_addr <= '0;
      dram_read_len  <= '0;
      arb_timeout    <= 1'b0;
      arb_stray      <= 1'b0;
    end else begin
      req_ready    <= '0;
      rsp_valid    <= '0;
      dram_read_en <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (dram_read_data_valid) arb_stray <= 1'b1;
          // Command registers load here so dram_read_en is high throughout ISSUE.
          if (found && !dram_read_busy) begin
            req_ready[pick] <= 1'b1;
            arb_grant_id    <= pick;
            dram_read_en    <= 1'b1;
            dram_read_addr  <= req_addr[pick*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            dram_read_len   <= req_len[pick*8 +: 8];
            state_q         <= StIssue;
          end
        end
        StIssue: begin
          if (dram_read_data_valid) arb_stray <= 1'b1;
          beat_cnt_q <= {1'b0, dram_read_len} + 9'd1;
          tmo_cnt_q  <= '0;
          state_q    <= StWaitData;
        end
        StWaitData: begin
          if (dram_read_data_valid) begin
            rsp_data                <= dram_read_data;
            rsp_valid[arb_grant_id] <= 1'b1;
            beat_cnt_q              <= beat_cnt_q - 9'd1;
            tmo_cnt_q               <= '0;
            if (beat_cnt_q == 9'd1) begin
              state_q  <= StIdle;
              rr_ptr_q <= rr_next;
            end
          end else if (tmo_cnt_q == TmoLast) begin
            arb_timeout <= 1'b1;
            state_q     <= StIdle;
            rr_ptr_q    <= rr_next;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Randomized bench for dram_read_arbiter: a per-cycle transaction model predicts every output
// from the arbitration, burst and timeout rules.
module tb_dram_read_arbiter;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int TMO = 16;
  localparam int GW  = 2;

  logic clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*8-1:0]  req_len;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   rsp_data;
  logic [N-1:0]    rsp_valid;
  logic [AW-1:0]   dram_read_addr;
  logic [7:0]      dram_read_len;
  logic            dram_read_en;
  logic [DW-1:0]   dram_read_data;
  logic            dram_read_data_valid;
  logic            dram_read_busy;
  logic [GW-1:0]   arb_grant_id;
  logic            arb_busy;
  logic            arb_timeout;
  logic            arb_stray;

  dram_read_arbiter #(
    .NUM_REQ         (N),
    .AXI_ADDR_WIDTH  (AW),
    .DRAM_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk_pixel            (clk_pixel),
    .dram_arbiter_reset   (rst),
    .req_valid            (req_valid),
    .req_addr             (req_addr),
    .req_len              (req_len),
    .req_ready            (req_ready),
    .rsp_data             (rsp_data),
    .rsp_valid            (rsp_valid),
    .dram_read_addr       (dram_read_addr),
    .dram_read_len        (dram_read_len),
    .dram_read_en         (dram_read_en),
    .dram_read_data       (dram_read_data),
    .dram_read_data_valid (dram_read_data_valid),
    .dram_read_busy       (dram_read_busy),
    .arb_grant_id         (arb_grant_id),
    .arb_busy             (arb_busy),
    .arb_timeout          (arb_timeout),
    .arb_stray            (arb_stray)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one burst record plus round-robin pointer and sticky flags.
  bit          m_active, m_cmd_cycle;
  int          m_owner, m_left, m_quiet, m_rr;
  logic [N-1:0]  e_ready, e_rsp_valid;
  logic [DW-1:0] e_rsp_data;
  logic          e_en, e_timeout, e_stray;
  logic [AW-1:0] e_addr;
  logic [7:0]    e_len;
  int            e_grant;

  // Requester-side stimulus state.
  bit [N-1:0]  pending;
  logic [AW-1:0] s_addr [N];
  logic [7:0]    s_len  [N];
  int            rst_hold;

  task automatic model_reset();
    m_active = 0; m_cmd_cycle = 0; m_owner = 0; m_left = 0; m_quiet = 0; m_rr = 0;
    e_ready = '0; e_rsp_valid = '0; e_rsp_data = '0; e_en = 0; e_timeout = 0; e_stray = 0;
    e_addr = '0; e_len = '0; e_grant = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    e_ready = '0; e_rsp_valid = '0; e_en = 0;
    if (!m_active) begin
      if (dram_read_data_valid) e_stray = 1;
      if (req_valid != '0 && !dram_read_busy) begin
        int w = -1;
        for (int k = 0; k < N; k++) begin
          int ix = (m_rr + k) % N;
          if (w < 0 && req_valid[ix]) w = ix;
        end
        e_ready[w]  = 1'b1;
        e_en        = 1;
        e_addr      = req_addr[w*AW +: AW];
        e_len       = req_len[w*8 +: 8];
        e_grant     = w;
        m_owner     = w;
        m_left      = int'(e_len) + 1;
        m_active    = 1;
        m_cmd_cycle = 1;
      end
    end else if (m_cmd_cycle) begin
      if (dram_read_data_valid) e_stray = 1;
      m_cmd_cycle = 0;
      m_quiet     = 0;
    end else if (dram_read_data_valid) begin
      e_rsp_valid[m_owner] = 1'b1;
      e_rsp_data = dram_read_data;
      m_left--;
      m_quiet = 0;
      if (m_left == 0) begin
        m_active = 0;
        m_rr     = (m_owner + 1) % N;
      end
    end else begin
      m_quiet++;
      if (m_quiet == TMO) begin
        e_timeout = 1;
        m_active  = 0;
        m_rr      = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic compare_all();
    check("req_ready", req_ready, e_ready);
    check("rsp_valid", rsp_valid, e_rsp_valid);
    check("rsp_data", rsp_data, e_rsp_data);
    check("dram_read_en", dram_read_en, e_en);
    check("dram_read_addr", dram_read_addr, e_addr);
    check("dram_read_len", dram_read_len, e_len);
    check("arb_grant_id", arb_grant_id, e_grant[GW-1:0]);
    check("arb_busy", arb_busy, m_active);
    check("arb_timeout", arb_timeout, e_timeout);
    check("arb_stray", arb_stray, e_stray);
  endtask

  task automatic run_phase(input int cycles, input int p_req, input int p_wd, input int p_long,
                           input int p_busy, input int p_dv, input int p_rst, input int len_max);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk_pixel);
      #1;
      compare_all();
      for (int i = 0; i < N; i++) begin
        if (pending[i] && e_ready[i]) begin
          pending[i] = 0;
        end else if (pending[i] && $urandom_range(99) < p_wd) begin
          pending[i] = 0;
        end else if (!pending[i] && $urandom_range(99) < p_req) begin
          pending[i] = 1;
          s_addr[i]  = $urandom;
          s_len[i]   = ($urandom_range(99) < p_long) ? 8'd255 : 8'($urandom_range(len_max));
        end
        req_valid[i]          = pending[i];
        req_addr[i*AW +: AW]  = s_addr[i];
        req_len[i*8 +: 8]     = s_len[i];
      end
      dram_read_busy       = ($urandom_range(99) < p_busy);
      dram_read_data_valid = ($urandom_range(99) < p_dv);
      dram_read_data       = {$urandom, $urandom};
      if (rst_hold > 0) begin
        rst = 1'b1;
        rst_hold--;
      end else begin
        rst = ($urandom_range(999) < p_rst);
      end
      model_step();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_len = '0;
    dram_read_data = '0;
    dram_read_data_valid = 1'b0;
    dram_read_busy = 1'b0;
    pending = '0;
    for (int i = 0; i < N; i++) begin
      s_addr[i] = '0;
      s_len[i]  = '0;
    end
    rst_hold = 2;
    model_reset();
    //          cycles req wd long busy dv rst len
    run_phase(200,   40,  5,  0,  20, 60, 0,  3);
    run_phase(300,  100,  0,  0,   0, 95, 0,  0);
    run_phase(300,   50,  0,  0,  90, 70, 0,  3);
    run_phase(800,   60,  0,  0,  10,  4, 0,  2);
    run_phase(1500,  30,  0, 10,  10, 95, 0,  7);
    run_phase(1500,  50,  3,  5,  10, 70, 4,  7);
    run_phase(1000,  50,  5,  2,  20, 50, 2, 15);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
